mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the store side of the single-cycle core's top level.
- Snoops the MemWrite/DataAddress/WriteData bus that also feeds data memory.
- Captures byte stores to a TX address into a small FIFO and serializes them as 8N1 frames on a single tx line.
- Exposes a combinational status word for loads from a STATUS address; the top muxes it into ReadData.

Parameters:
TX_ADDR, 32'h0000_0100, store address whose WriteData[7:0] is queued for transmission
STAT_ADDR, 32'h0000_0104, status register address (read: status; write bit0=1: clear overflow)
CLKS_PER_BIT, 16, clock cycles per UART bit (>=2)
FIFO_DEPTH, 4, byte FIFO entries (power of two, >=2)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
MemWrite  input  1  core store strobe
DataAddress  input  32  core ALUResult/data address
WriteData  input  32  core store data
StatusRD  output  32  combinational status read data; 0 when DataAddress != STAT_ADDR
tx  output  1  registered serial line, idle high
busy  output  1  combinational: FSM not IDLE or FIFO not empty
overflow  output  1  sticky: a TX store was dropped because the FIFO was full

Behaviour:
- Reset (reset==0 at edge): tx=1, FSM=IDLE, FIFO count/pointers=0, overflow=0, bit/baud counters=0. Reset mid-frame aborts the frame and flushes the FIFO; tx is high after that edge.
- Push: MemWrite && DataAddress==TX_ADDR at an edge pushes WriteData[7:0] if count<FIFO_DEPTH. Otherwise the byte is dropped and overflow is set.
- Clear: MemWrite && DataAddress==STAT_ADDR && WriteData[0] clears overflow. If a drop occurs in the same cycle, the set wins (impossible by address, listed for completeness).
- Other addresses are ignored. Stores are accepted every cycle; there is no back-pressure to the core.
- Simultaneous push and pop:
  - Count unchanged.
  - When full, the pop frees the slot, so the push is accepted with no overflow.
  - When empty, a pop cannot occur, so the push lands and is popped no earlier than the next edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO not empty at an edge: pop head into an 8-bit shift register, baud counter=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit index 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- tx is registered from state and shift register; it changes only on the edge that enters a state or bit.
- Latency: a store at edge k makes tx fall after edge k+1.
- Frame: exactly 10*CLKS_PER_BIT cycles low-start to end-of-stop. Back-to-back queued bytes are separated by exactly 1 IDLE cycle (period 10*CLKS_PER_BIT+1).
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is clog2(CLKS_PER_BIT).
- Pointers wrap modulo FIFO_DEPTH. The count register is clog2(FIFO_DEPTH)+1 bits wide.
- StatusRD = {28'b0, overflow, full, empty, busy} when DataAddress==STAT_ADDR, else 32'b0. Purely combinational, so a load sees the value before the edge.

Decomposition:
- Shared package mmio_pkg holds:
  - TX FSM state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
  - Default TX_ADDR/STAT_ADDR constants.
  - Status bit indices (BUSY=0, EMPTY=1, FULL=2, OVF=3).
- One sub-module, sync_byte_fifo (parameter DEPTH). Ports: clk, reset, push, din[7:0], pop, dout[7:0], full, empty, count.
- Top wires the address decode, overflow flag and serializer FSM around it.

Test Plan:
- Reset: hold reset=0 for 3 cycles with a TX store asserted -> tx=1, StatusRD@0x104=32'h2 (empty only), busy=0, overflow=0; nothing transmitted afterwards.
- Single byte, CLKS_PER_BIT=4: store 32'hFFFF_FFA5 to 0x100 -> tx low one cycle after, then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high 4 cycles; 40 cycles total; busy drops after STOP; upper WriteData bits ignored.
- Burst/overflow: 6 stores on consecutive cycles, bytes 0x11..0x16 -> 0x11..0x15 transmitted in order with 1 IDLE cycle between frames; 0x16 dropped; overflow=1 and StatusRD bit3=1 after the 6th edge.
- Clear + full-with-pop: store 1 to 0x104 -> overflow=0. Fill FIFO to 4, then push on the edge where IDLE pops -> byte accepted, overflow stays 0.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> tx=1 after that edge, StatusRD=32'h2; no further frames.
- Decode: stores to 0x0FC, 0x108 and loads at 0x100 -> no push; StatusRD=0 for any address other than 0x104.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// default bus addresses and status word bit positions.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic [31:0] DEF_TX_ADDR   = 32'h0000_0100;
    localparam logic [31:0] DEF_STAT_ADDR = 32'h0000_0104;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_OVF   = 3;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous byte FIFO with a show-ahead head; a push while full is
// accepted when a pop frees the slot in the same cycle.
module sync_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-bus snooping UART transmitter: queues bytes written to TX_ADDR and
// sends them as 8N1 frames; exposes a combinational status word.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] TX_ADDR      = DEF_TX_ADDR,
    parameter logic [31:0] STAT_ADDR    = DEF_STAT_ADDR,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAddress,
    input  logic [31:0] WriteData,
    output logic [31:0] StatusRD,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t   state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift, shift_n;
    logic        tx_n;
    logic        pop;
    logic        bit_end;

    logic        tx_store;
    logic        clr_store;
    logic        push_ok;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign tx_store  = MemWrite && (DataAddress == TX_ADDR);
    assign clr_store = MemWrite && (DataAddress == STAT_ADDR) && WriteData[0];
    assign push_ok   = tx_store && (!fifo_full || pop);

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .din   (WriteData[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = (baud == BAUD_LAST);

    always_comb begin
        state_n   = state;
        baud_n    = bit_end ? '0 : baud + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = tx;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                baud_n = '0;
                tx_n   = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    state_n = ST_START;
                    tx_n    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n   = ST_DATA;
                    bit_idx_n = 3'd0;
                    tx_n      = shift[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_n = ST_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        // Next bit is driven from the pre-shift value so tx and shift stay aligned.
                        shift_n   = {1'b0, shift[7:1]};
                        tx_n      = shift[1];
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_n = ST_IDLE;
                    tx_n    = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            tx      <= tx_n;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_n;
    end

    // A drop outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset)
            overflow <= 1'b0;
        else if (tx_store && !push_ok)
            overflow <= 1'b1;
        else if (clr_store)
            overflow <= 1'b0;
    end

    assign busy = (state != ST_IDLE) || !fifo_empty;

    always_comb begin
        StatusRD = 32'b0;
        if (DataAddress == STAT_ADDR) begin
            StatusRD[STAT_BUSY]  = busy;
            StatusRD[STAT_EMPTY] = fifo_empty;
            StatusRD[STAT_FULL]  = fifo_full;
            StatusRD[STAT_OVF]   = overflow;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random bus traffic against
// a frame-timeline reference model (byte queue + position within 10-bit frame).
module tb_mmio_uart_tx;

    localparam int N = 4;
    localparam int D = 4;
    localparam logic [31:0] A_TX   = 32'h0000_0100;
    localparam logic [31:0] A_STAT = 32'h0000_0104;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAddress;
    logic [31:0] WriteData;
    logic [31:0] StatusRD;
    logic        tx;
    logic        busy;
    logic        overflow;

    mmio_uart_tx #(
        .TX_ADDR      (A_TX),
        .STAT_ADDR    (A_STAT),
        .CLKS_PER_BIT (N),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAddress (DataAddress),
        .WriteData   (WriteData),
        .StatusRD    (StatusRD),
        .tx          (tx),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: accepted-byte queue, current frame bits and time within it.
    logic [7:0] q[$];
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [9:0] m_frame  = 10'h3FF;
    bit         m_ovf    = 1'b0;

    function automatic logic m_tx();
        return m_active ? m_frame[m_t / N] : 1'b1;
    endfunction

    function automatic logic m_busy();
        return m_active || (q.size() != 0);
    endfunction

    function automatic logic [31:0] m_status(input logic [31:0] a);
        logic [31:0] s;
        s = 32'b0;
        if (a == A_STAT) begin
            s[0] = m_busy();
            s[1] = (q.size() == 0);
            s[2] = (q.size() == D);
            s[3] = m_ovf;
        end
        return s;
    endfunction

    task automatic step(input logic rst_n, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
        logic [7:0] b;
        @(negedge clk);
        reset = rst_n; MemWrite = we; DataAddress = a; WriteData = d;
        #1;
        chk({tag, ":status"}, StatusRD, m_status(a));
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_ovf    = 1'b0;
        end else begin
            if (m_active) begin
                m_t++;
                if (m_t == 10 * N) m_active = 1'b0;
            end else if (q.size() > 0) begin
                b        = q.pop_front();
                m_frame  = {1'b1, b, 1'b0};
                m_active = 1'b1;
                m_t      = 0;
            end
            if (we && a == A_TX) begin
                if (q.size() < D) q.push_back(d[7:0]);
                else              m_ovf = 1'b1;
            end else if (we && a == A_STAT && d[0]) begin
                m_ovf = 1'b0;
            end
        end
        #1;
        chk({tag, ":tx"},       32'(tx),       32'(m_tx()));
        chk({tag, ":busy"},     32'(busy),     32'(m_busy()));
        chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 32'h0, "idle");
    endtask

    initial begin
        int guard;
        logic [31:0] addr_tab [5];
        addr_tab[0] = A_TX; addr_tab[1] = A_TX; addr_tab[2] = A_STAT;
        addr_tab[3] = 32'h0000_00FC; addr_tab[4] = 32'h0000_0108;

        reset = 1'b0; MemWrite = 1'b0; DataAddress = '0; WriteData = '0;

        // Reset held with a TX store on the bus
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, A_TX, 32'h55, "rst");
        step(1'b1, 1'b0, A_STAT, 32'h0, "rst_stat");
        chk("rst_status_word", StatusRD, 32'h2);
        chk("rst_tx", 32'(tx), 32'h1);
        idle(20);

        // Single byte, upper data bits ignored
        step(1'b1, 1'b1, A_TX, 32'hFFFF_FFA5, "single_store");
        step(1'b1, 1'b0, 32'h0, 32'h0, "single_first");
        chk("single_start_low", 32'(tx), 32'h0);
        idle(45);
        chk("single_done_busy", 32'(busy), 32'h0);

        // Burst of six; the sixth is dropped
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, A_TX, 32'h11 + 32'(i), "burst");
        chk("burst_overflow", 32'(overflow), 32'h1);
        step(1'b1, 1'b0, A_STAT, 32'h0, "burst_stat");
        chk("burst_stat_bit3", 32'(StatusRD[3]), 32'h1);
        idle(5 * (10 * N + 1) + 5);

        // Clear overflow, then push on the IDLE pop edge while full
        step(1'b1, 1'b1, A_STAT, 32'h1, "clear");
        chk("clear_overflow", 32'(overflow), 32'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, A_TX, 32'h21 + 32'(i), "fill");
        guard = 0;
        while (!(!m_active && q.size() > 0) && guard < 200) begin
            idle(1);
            guard++;
        end
        chk("fill_wait_bound", 32'(guard < 200), 32'h1);
        chk("fill_full_before", 32'(q.size()), 32'(D));
        step(1'b1, 1'b1, A_TX, 32'h26, "push_on_pop");
        chk("push_on_pop_ovf", 32'(overflow), 32'h0);
        idle(5 * (10 * N + 1) + 5);

        // Reset during data bit 3 with bytes still queued
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, A_TX, 32'h31 + 32'(i), "midq");
        guard = 0;
        while (!(m_active && (m_t / N) == 4) && guard < 100) begin
            idle(1);
            guard++;
        end
        chk("mid_wait_bound", 32'(guard < 100), 32'h1);
        step(1'b0, 1'b0, 32'h0, 32'h0, "mid_rst");
        chk("mid_rst_tx", 32'(tx), 32'h1);
        step(1'b1, 1'b0, A_STAT, 32'h0, "mid_stat");
        chk("mid_status_word", StatusRD, 32'h2);
        idle(50);

        // Address decode
        step(1'b1, 1'b1, 32'h0000_00FC, 32'h77, "dec_fc");
        step(1'b1, 1'b1, 32'h0000_0108, 32'h77, "dec_108");
        step(1'b1, 1'b0, A_TX, 32'h77, "dec_load");
        chk("dec_status_zero", StatusRD, 32'h0);
        chk("dec_busy", 32'(busy), 32'h0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic        r_we;
            logic        r_rst;
            logic [31:0] r_a;
            r_we  = ($urandom_range(0, 9) < 3);
            r_rst = ($urandom_range(0, 299) != 0);
            r_a   = ($urandom_range(0, 7) == 0) ? $urandom : addr_tab[$urandom_range(0, 4)];
            step(r_rst, r_we, r_a, $urandom, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
